// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared definitions for the 7-segment display interface.
// Segment bus bit order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
// The same pattern constants are used by the display driver and the
// capture side, so the encoding and the decoding always agree.
package seven_seg_pkg;

  // Bit positions inside the 7-bit segment bus.
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  // Active-low patterns for hex digits 0..F.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Capture-side control state; visible on hex_valid / invalid_pat.
  typedef enum logic [1:0] {
    ST_NOVAL  = 2'd0,
    ST_LOCKED = 2'd1,
    ST_BAD    = 2'd2
  } ctl_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational lookup from an active-low segment
// pattern to its hex value.
//   pattern_i : 7-bit segment pattern {g,f,e,d,c,b,a}
//   valid_o   : 1 when the pattern is one of the 16 legal digits
//   hex_o     : decoded digit (0 when the pattern is not legal)
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       valid_o,
  output logic [3:0] hex_o
);

  // Pattern lookup; blank and every unlisted pattern decode as invalid.
  always_comb begin
    valid_o = 1'b1;
    hex_o   = 4'h0;
    case (pattern_i)
      SEG_0:   hex_o = 4'h0;
      SEG_1:   hex_o = 4'h1;
      SEG_2:   hex_o = 4'h2;
      SEG_3:   hex_o = 4'h3;
      SEG_4:   hex_o = 4'h4;
      SEG_5:   hex_o = 4'h5;
      SEG_6:   hex_o = 4'h6;
      SEG_7:   hex_o = 4'h7;
      SEG_8:   hex_o = 4'h8;
      SEG_9:   hex_o = 4'h9;
      SEG_A:   hex_o = 4'hA;
      SEG_B:   hex_o = 4'hB;
      SEG_C:   hex_o = 4'hC;
      SEG_D:   hex_o = 4'hD;
      SEG_E:   hex_o = 4'hE;
      SEG_F:   hex_o = 4'hF;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples an asynchronous active-low segment bus,
// debounces it, decodes stable patterns to hex and classifies each change.
//   in_clk      : sampling clock
//   reset       : asynchronous, active-low
//   seg_in      : raw segment bus {g,f,e,d,c,b,a}, asynchronous to in_clk
//   clr_err     : synchronous clear of err_count (beats an increment)
//   hex_out     : last accepted legal digit
//   hex_valid   : last accepted pattern was legal
//   invalid_pat : last accepted pattern was illegal or blank
//   new_strobe  : 1-cycle pulse on a new hex_out value or hex_valid rising
//   dir_up      : 1-cycle pulse, new = old+1 mod 16
//   dir_down    : 1-cycle pulse, new = old-1 mod 16
//   jump        : 1-cycle pulse, any other change between legal values
//   err_count   : saturating count of jumps plus illegal acceptances
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clr_err,
  output logic [3:0]       hex_out,
  output logic             hex_valid,
  output logic             invalid_pat,
  output logic             new_strobe,
  output logic             dir_up,
  output logic             dir_down,
  output logic             jump,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  logic [6:0]       s1_q, s2_q;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  ctl_state_e       state_q, state_d;
  logic [3:0]       hex_q, hex_d;
  logic             strobe_q, strobe_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             jump_q, jump_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             same_s;
  logic             accept_s;
  logic             dec_valid_s;
  logic [3:0]       dec_hex_s;
  logic [3:0]       hex_inc_s;
  logic [3:0]       hex_dec_s;
  logic             err_inc_s;

  seg_pattern_decode u_decode (
    .pattern_i (s2_q),
    .valid_o   (dec_valid_s),
    .hex_o     (dec_hex_s)
  );

  // A pattern is accepted once it has matched for STABLE_CYCLES-1 prior
  // edges; the counter then parks at STABLE_CYCLES so it is not re-accepted.
  assign same_s    = (s1_q == s2_q);
  assign accept_s  = same_s && (stab_cnt_q == STABLE_M1);
  assign hex_inc_s = hex_q + 4'd1;
  assign hex_dec_s = hex_q - 4'd1;

  // Synchronizer, stability counter and control state register.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= SEG_BLANK;
      s2_q       <= SEG_BLANK;
      stab_cnt_q <= 8'd0;
      state_q    <= ST_NOVAL;
    end else begin
      s1_q       <= seg_in;
      s2_q       <= s1_q;
      stab_cnt_q <= stab_cnt_d;
      state_q    <= state_d;
    end
  end

  // Datapath registers: digit, pulses and error counter.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      hex_q    <= 4'h0;
      strobe_q <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      jump_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      hex_q    <= hex_d;
      strobe_q <= strobe_d;
      up_q     <= up_d;
      down_q   <= down_d;
      jump_q   <= jump_d;
      err_q    <= err_d;
    end
  end

  // Stability counter next value.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (!same_s) begin
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q < STABLE_C) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
  end

  // Control state transitions on each acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NOVAL, ST_LOCKED, ST_BAD: begin
        if (accept_s) begin
          state_d = dec_valid_s ? ST_LOCKED : ST_BAD;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_NOVAL;
    endcase
  end

  // Classifier: a valid acceptance outside LOCKED is a first value and
  // never produces a direction pulse.
  always_comb begin
    hex_d     = hex_q;
    strobe_d  = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    jump_d    = 1'b0;
    err_inc_s = 1'b0;
    if (accept_s) begin
      if (!dec_valid_s) begin
        err_inc_s = 1'b1;
      end else if (state_q != ST_LOCKED) begin
        hex_d    = dec_hex_s;
        strobe_d = 1'b1;
      end else if (dec_hex_s != hex_q) begin
        hex_d    = dec_hex_s;
        strobe_d = 1'b1;
        if (dec_hex_s == hex_inc_s) begin
          up_d = 1'b1;
        end else if (dec_hex_s == hex_dec_s) begin
          down_d = 1'b1;
        end else begin
          jump_d    = 1'b1;
          err_inc_s = 1'b1;
        end
      end else begin
        hex_d = hex_q;
      end
    end
  end

  // Error counter: clear wins, otherwise saturating increment.
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = '0;
    end else if (err_inc_s && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_d = err_q;
    end
  end

  // Outputs: state flags decoded from the state register.
  always_comb begin
    hex_valid   = 1'b0;
    invalid_pat = 1'b0;
    case (state_q)
      ST_NOVAL:  begin hex_valid = 1'b0; invalid_pat = 1'b0; end
      ST_LOCKED: begin hex_valid = 1'b1; invalid_pat = 1'b0; end
      ST_BAD:    begin hex_valid = 1'b0; invalid_pat = 1'b1; end
      default:   begin hex_valid = 1'b0; invalid_pat = 1'b0; end
    endcase
  end

  assign hex_out    = hex_q;
  assign new_strobe = strobe_q;
  assign dir_up     = up_q;
  assign dir_down   = down_q;
  assign jump       = jump_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: a queue-based reference model judged on
// every falling clock edge, plus directed scenarios with literal checks.
module tb_seven_seg_capture;

  localparam int STABLE = 4;
  localparam int EW     = 8;

  logic          in_clk = 1'b0;
  logic          reset  = 1'b1;
  logic [6:0]    seg_in = 7'h7F;
  logic          clr_err = 1'b0;
  logic [3:0]    hex_out;
  logic          hex_valid, invalid_pat, new_strobe, dir_up, dir_down, jump;
  logic [EW-1:0] err_count;

  int tests = 0;
  int fails = 0;

  seven_seg_capture #(.STABLE_CYCLES(STABLE), .ERR_W(EW)) dut (
    .in_clk(in_clk), .reset(reset), .seg_in(seg_in), .clr_err(clr_err),
    .hex_out(hex_out), .hex_valid(hex_valid), .invalid_pat(invalid_pat),
    .new_strobe(new_strobe), .dir_up(dir_up), .dir_down(dir_down),
    .jump(jump), .err_count(err_count)
  );

  always #5 in_clk = ~in_clk;

  // ---------------- reference model ----------------
  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] hist [$];
  int  m_hex = 0, m_err = 0;
  bit  m_valid = 0, m_inv = 0, m_strobe = 0, m_up = 0, m_down = 0, m_jump = 0;

  function automatic int trailing_run();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  // hist holds every bus sample taken since reset, with two blank entries
  // standing for the reset state of the sampler; a pattern counts as
  // accepted when its most recent run reaches exactly STABLE+1 samples.
  always @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      hist.delete();
      hist.push_back(7'h7F);
      hist.push_back(7'h7F);
      m_hex = 0; m_err = 0;
      m_valid = 0; m_inv = 0;
      m_strobe = 0; m_up = 0; m_down = 0; m_jump = 0;
    end else begin
      int  v;
      bit  inc;
      v = -1; inc = 0;
      m_strobe = 0; m_up = 0; m_down = 0; m_jump = 0;
      if (hist.size() >= 2 && trailing_run() == STABLE + 1) begin
        for (int k = 0; k < 16; k++) if (pat_tab[k] == hist[hist.size() - 1]) v = k;
        if (v < 0) begin
          m_valid = 0; m_inv = 1; inc = 1;
        end else if (!m_valid) begin
          m_hex = v; m_valid = 1; m_inv = 0; m_strobe = 1;
        end else if (v != m_hex) begin
          m_strobe = 1;
          if ((v - m_hex + 16) % 16 == 1) m_up = 1;
          else if ((m_hex - v + 16) % 16 == 1) m_down = 1;
          else begin m_jump = 1; inc = 1; end
          m_hex = v;
        end
      end
      if (clr_err) m_err = 0;
      else if (inc) m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
      hist.push_back(seg_in);
      if (hist.size() > 300) void'(hist.pop_front());
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge in_clk) begin
    check("hex_out",     int'(hex_out),     m_hex);
    check("hex_valid",   int'(hex_valid),   int'(m_valid));
    check("invalid_pat", int'(invalid_pat), int'(m_inv));
    check("new_strobe",  int'(new_strobe),  int'(m_strobe));
    check("dir_up",      int'(dir_up),      int'(m_up));
    check("dir_down",    int'(dir_down),    int'(m_down));
    check("jump",        int'(jump),        int'(m_jump));
    check("err_count",   int'(err_count),   m_err);
  end

  // Sticky record of pulses seen since the last clear.
  bit saw_strobe, saw_up, saw_down, saw_jump;
  always @(negedge in_clk) begin
    if (new_strobe) saw_strobe = 1;
    if (dir_up)     saw_up     = 1;
    if (dir_down)   saw_down   = 1;
    if (jump)       saw_jump   = 1;
  end

  task automatic clear_saw();
    saw_strobe = 0; saw_up = 0; saw_down = 0; saw_jump = 0;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    @(posedge in_clk); #2;
    seg_in = p;
    clear_saw();
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic check_pulses(input string name, input bit s, input bit u, input bit d, input bit j);
    check({name, "_strobe"}, int'(saw_strobe), int'(s));
    check({name, "_up"},     int'(saw_up),     int'(u));
    check({name, "_down"},   int'(saw_down),   int'(d));
    check({name, "_jump"},   int'(saw_jump),   int'(j));
  endtask

  initial begin
    #1 reset = 1'b0;
    seg_in = 7'h7F;
    repeat (3) @(posedge in_clk);
    #1;
    check("rst_hex", int'(hex_out), 0);
    check("rst_flags", int'({hex_valid, invalid_pat, new_strobe, dir_up, dir_down, jump}), 0);
    check("rst_err", int'(err_count), 0);

    // Blank held through release: accepted as an invalid pattern.
    @(posedge in_clk); #2 reset = 1'b1;
    clear_saw();
    repeat (10) @(posedge in_clk); #1;
    check("blank_inv", int'(invalid_pat), 1);
    check("blank_valid", int'(hex_valid), 0);
    check("blank_err", int'(err_count), 1);
    check_pulses("blank", 0, 0, 0, 0);

    hold(7'h40, 10);                       // first value 0
    check("first_hex", int'(hex_out), 0);
    check("first_valid", int'(hex_valid), 1);
    check_pulses("first", 1, 0, 0, 0);
    hold(7'h79, 10);                       // 0 -> 1
    check("up_hex", int'(hex_out), 1);
    check("up_err", int'(err_count), 1);
    check_pulses("up01", 1, 1, 0, 0);
    hold(7'h0E, 10);                       // 1 -> F is a jump
    check_pulses("jmp1F", 1, 0, 0, 1);
    check("jmp1F_err", int'(err_count), 2);
    hold(7'h40, 10);                       // F -> 0 wraps up
    check("wrap_up_hex", int'(hex_out), 0);
    check_pulses("wrapup", 1, 1, 0, 0);
    hold(7'h0E, 10);                       // 0 -> F wraps down
    check("wrap_dn_hex", int'(hex_out), 15);
    check_pulses("wrapdn", 1, 0, 1, 0);
    hold(7'h30, 10);                       // F -> 3 jump
    hold(7'h12, 10);                       // 3 -> 5 jump
    check("jump_hex", int'(hex_out), 5);
    check("jump_err", int'(err_count), 4);
    check_pulses("jump35", 1, 0, 0, 1);

    // Three-cycle glitch to 2 between stable 5 samples.
    hold(7'h24, 3);
    hold(7'h12, 10);
    check("glitch_hex", int'(hex_out), 5);
    check("glitch_err", int'(err_count), 4);
    check_pulses("glitch", 0, 0, 0, 0);

    // Saturation with alternating illegal patterns.
    for (int i = 0; i < 140; i++) begin
      hold(7'h7F, 7);
      hold(7'h7E, 7);
    end
    check("sat_err", int'(err_count), 255);

    // clr_err on exactly the edge of an invalid acceptance.
    @(posedge in_clk); #2 seg_in = 7'h7F;
    repeat (5) @(posedge in_clk);
    #2 clr_err = 1'b1;
    @(posedge in_clk);
    #2 clr_err = 1'b0;
    check("clr_err", int'(err_count), 0);
    check("clr_inv", int'(invalid_pat), 1);

    // Reset two cycles into settling of digit 1.
    hold(7'h40, 10);
    @(posedge in_clk); #2 seg_in = 7'h79;
    repeat (2) @(posedge in_clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_flags", int'({hex_valid, invalid_pat, new_strobe, dir_up, dir_down, jump}), 0);
    check("midrst_hex", int'(hex_out), 0);
    check("midrst_err", int'(err_count), 0);
    @(posedge in_clk); #2 reset = 1'b1;
    clear_saw();
    repeat (12) @(posedge in_clk); #1;
    check("post_hex", int'(hex_out), 1);
    check("post_valid", int'(hex_valid), 1);
    check_pulses("post", 1, 0, 0, 0);

    repeat (2) @(posedge in_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receiving end of the team's 7-segment display interface. Samples an active-low 7-bit segment bus (bit order g,f,e,d,c,b,a) from an external board, display model or scan tap.
- Debounces the bus, decodes each stable pattern back to a 4-bit hex value, and flags illegal or blank patterns.
- Classifies each value change as up-step, down-step or jump, so a bench or self-test can check an up/down hex counter from its display outputs alone.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples needed to accept a pattern; legal range 2..255
ERR_W, 8, width of the saturating error counter

Ports:
in_clk  input  1  sampling clock
reset  input  1  asynchronous, active-low
seg_in  input  7  raw segment bus, active-low, {g,f,e,d,c,b,a}, asynchronous to in_clk
clr_err  input  1  synchronous clear of err_count, highest priority over increment
hex_out  output  4  last accepted valid hex value
hex_valid  output  1  1 = most recent accepted pattern was a legal digit
invalid_pat  output  1  1 = most recent accepted pattern was illegal or blank
new_strobe  output  1  one-cycle pulse when hex_out takes a new value or hex_valid rises
dir_up  output  1  one-cycle pulse: new value = old+1 mod 16
dir_down  output  1  one-cycle pulse: new value = old-1 mod 16
jump  output  1  one-cycle pulse: any other change between two valid values
err_count  output  ERR_W  saturating count of jump events plus invalid-pattern acceptances

Behaviour:
- Reset (async, while low):
  - sync flops s1, s2 = 7'h7F; stab_cnt = 0; hex_out = 0.
  - hex_valid, invalid_pat, all pulse outputs = 0; err_count = 0.
  - Reset mid-operation discards any pattern in settling. The first acceptance after release is treated as a first value.
- Synchronizer: s1 <= seg_in; s2 <= s1 every edge.
- Stability counter, evaluated each edge:
  - if s1 != s2: stab_cnt <= 0
  - else if stab_cnt < STABLE_CYCLES: stab_cnt <= stab_cnt + 1
- Acceptance occurs on the edge where s1 == s2 and stab_cnt == STABLE_CYCLES-1. The counter then saturates at STABLE_CYCLES, so there is no re-acceptance until the bus changes.
- Latency: seg_in changed before edge E0 and held. Outputs update at edge E0+STABLE_CYCLES+1 (E5 for default).
- Glitches: glitch shorter than STABLE_CYCLES cycles is ignored; a glitch back to the old pattern causes no event.
- Decode table, hex -> pattern:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Any other pattern, including blank 7F, is invalid.
- On acceptance of a valid pattern with value v:
  - hex_valid was 0: hex_out <= v; hex_valid <= 1; invalid_pat <= 0; new_strobe pulse only. No direction pulse.
  - hex_valid was 1 and v != hex_out: hex_out <= v; new_strobe pulse, plus exactly one of dir_up / dir_down / jump.
  - Wrap-around counts as a step: F->0 gives dir_up; 0->F gives dir_down.
  - jump also increments err_count.
- On acceptance of an invalid pattern:
  - hex_valid <= 0; invalid_pat <= 1; hex_out holds; no pulses; err_count increments.
- Pulses are registered, high exactly one cycle, and mutually exclusive (dir_up/dir_down/jump).
- err_count:
  - saturates at all-ones;
  - clr_err on the same edge as an increment wins and yields 0.
- Control states, encoded in hex_valid/invalid_pat:
  - NOVAL (both 0, after reset): goes to LOCKED on a valid acceptance, or BAD on an invalid one.
  - LOCKED (hex_valid=1): a valid acceptance stays in LOCKED; an invalid acceptance goes to BAD.
  - BAD (invalid_pat=1): a valid acceptance goes to LOCKED as a first value; an invalid acceptance stays in BAD.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16 segment pattern constants SEG_0..SEG_F;
  - SEG_BLANK = 7'h7F;
  - the bit-order definition;
  - shared with the display driver.
- Sub-module seg_pattern_decode: combinational 7->{valid, hex[3:0]} lookup using the package constants.
- Top module holds synchronizer, stability counter, classifier and error counter.

Test Plan:
- Reset low, then release with seg_in=7F held -> at E5 invalid_pat=1, hex_valid=0, err_count=1, no strobe.
- seg_in=40 then 79, each held 10 cycles -> first acceptance: hex_out=0, new_strobe only; second: hex_out=1, new_strobe+dir_up; err_count unchanged.
- Hold 0E (F) then 40 (0); then 40 then 0E -> dir_up on F->0, dir_down on 0->F.
- From hex_out=3, apply 12 (5) -> jump pulse, hex_out=5, err_count+1. Apply 3-cycle glitch 24 between stable 12 samples -> no pulse, no change.
- Saturation: drive ERR_W=8 past 255 error events -> err_count=FF. Assert clr_err together with an error event -> err_count=00.
- Assert reset mid-settle, 2 cycles after seg_in change -> all outputs 0 immediately. After release, the first valid digit gives new_strobe only, no direction pulse.
